// File: rtl/search_pkg.sv
// Shared constants and state encoding for the text search sequencer.
package search_pkg;

  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_ETX = 8'h03;
  localparam int         MAX_WORD  = 5;
  localparam int         CC_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    SCAN,
    DONE
  } state_e;

endpackage

// File: rtl/search_sequencer_word_tracker.sv
// Tracks the length and overflow of the word under scan plus the count of
// completed non-empty words. Its length register drives the engine CharCount.
module word_tracker
  import search_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             sp_ev,
  input  logic             char_ev,
  output logic [CC_W-1:0]  char_count,
  output logic             qual,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [CC_W-1:0] MAX_LEN = CC_W'(MAX_WORD);

  logic [CC_W-1:0]  len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next length/overflow/count from the per-byte space or character event.
  always_comb begin
    len_d = len_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr) begin
      len_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (sp_ev) begin
      // Runs of spaces close only one word; empty words are never counted.
      if (len_q != '0) cnt_d = cnt_q + CNT_W'(1);
      len_d = '0;
      ovf_d = 1'b0;
    end else if (char_ev) begin
      // Length saturates at the engine's word size; extra chars mark overflow.
      if (len_q == MAX_LEN) ovf_d = 1'b1;
      else                  len_d = len_q + CC_W'(1);
    end
  end

  // Tracker state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign char_count = len_q;
  assign qual       = (len_q != '0) && !ovf_q;
  assign word_cnt   = cnt_q;

endmodule

// File: rtl/search_sequencer.sv
// Sequences one search: pulses the engine load, streams SRAM text bytes,
// qualifies raw engine matches and reports hit / end-of-text / exhaustion.
module search_sequencer
  import search_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_ADDR = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_re,
  output logic              eng_new,
  output logic [CC_W-1:0]   CharCount,
  input  logic              sp,
  input  logic              ETX,
  input  logic              match,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              err,
  output logic [ADDR_W-1:0] match_addr,
  output logic [ADDR_W-1:0] word_idx
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              sram_re_q, sram_re_d;
  logic              eng_new_q, eng_new_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] match_addr_q, match_addr_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;

  logic              trk_clr, trk_sp, trk_char, trk_qual;
  logic [ADDR_W-1:0] trk_cnt;
  logic [ADDR_W-1:0] cur_addr;

  word_tracker #(.CNT_W(ADDR_W)) u_tracker (
    .clock      (clock),
    .reset      (reset),
    .clr        (trk_clr),
    .sp_ev      (trk_sp),
    .char_ev    (trk_char),
    .char_count (CharCount),
    .qual       (trk_qual),
    .word_cnt   (trk_cnt)
  );

  // Read data lags the address by one cycle, so the byte on the bus is the
  // one addressed last cycle.
  assign cur_addr = sram_addr_q - ADDR_W'(1);

  // Next-state and output decode, with hit > ETX > exhaustion > space > char.
  always_comb begin
    state_d      = state_q;
    sram_addr_d  = sram_addr_q;
    sram_re_d    = sram_re_q;
    eng_new_d    = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    found_d      = found_q;
    err_d        = err_q;
    match_addr_d = match_addr_q;
    word_idx_d   = word_idx_q;
    trk_clr      = 1'b0;
    trk_sp       = 1'b0;
    trk_char     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = PRIME;
          eng_new_d    = 1'b1;
          sram_addr_d  = '0;
          sram_re_d    = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          found_d      = 1'b0;
          err_d        = 1'b0;
          match_addr_d = '0;
          word_idx_d   = '0;
          trk_clr      = 1'b1;
        end
      end
      PRIME: begin
        sram_addr_d = ADDR_W'(1);
        state_d     = SCAN;
      end
      SCAN: begin
        sram_addr_d = sram_addr_q + ADDR_W'(1);
        if ((match && trk_qual) || ETX || (cur_addr == LAST_ADDR)) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          sram_re_d = 1'b0;
          if (match && trk_qual) begin
            found_d      = 1'b1;
            match_addr_d = cur_addr;
            word_idx_d   = trk_cnt;
          end else if (!ETX) begin
            err_d = 1'b1;
          end
        end else if (sp) begin
          trk_sp = 1'b1;
        end else begin
          trk_char = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State machine and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sram_addr_q  <= '0;
      sram_re_q    <= 1'b0;
      eng_new_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      err_q        <= 1'b0;
      match_addr_q <= '0;
      word_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      sram_addr_q  <= sram_addr_d;
      sram_re_q    <= sram_re_d;
      eng_new_q    <= eng_new_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      err_q        <= err_d;
      match_addr_q <= match_addr_d;
      word_idx_q   <= word_idx_d;
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_re    = sram_re_q;
  assign eng_new    = eng_new_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign err        = err_q;
  assign match_addr = match_addr_q;
  assign word_idx   = word_idx_q;

endmodule

// File: tb/tb_search_sequencer.sv
// Bench for search_sequencer: SRAM and string-match engine models around the
// DUT, a spec-level reference search feeding a result scoreboard.
module tb_search_sequencer;
  import search_pkg::*;

  typedef struct {
    logic       found;
    logic       err;
    logic [9:0] maddr;
    logic [9:0] widx;
    int         lat;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] sram_addr;
  logic       sram_re;
  logic       eng_new;
  logic [2:0] CharCount;
  logic       sp, ETX, match;
  logic       busy, done, found, err;
  logic [9:0] match_addr, word_idx;

  logic [7:0] mem [0:1023];
  logic [7:0] rdata;
  logic [7:0] sword [0:4];
  int         wl;
  logic       ok_q, ok_eff, valid_q;
  int         new_pulses = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       exp_q [$];

  search_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .sram_addr  (sram_addr),
    .sram_re    (sram_re),
    .eng_new    (eng_new),
    .CharCount  (CharCount),
    .sp         (sp),
    .ETX        (ETX),
    .match      (match),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .err        (err),
    .match_addr (match_addr),
    .word_idx   (word_idx)
  );

  always #5 clock = ~clock;

  // Synchronous SRAM, one-cycle read latency.
  always @(posedge clock) if (sram_re) rdata <= mem[sram_addr];

  assign sp  = (rdata == ASCII_SP);
  assign ETX = (rdata == ASCII_ETX);

  // Engine model: per-position compare, bytes at CharCount>=5 discarded.
  always_comb begin
    ok_eff = (CharCount == 3'd0) ? 1'b1 : ok_q;
    match  = 1'b0;
    if ((sp || ETX) && ok_eff) begin
      if (CharCount >= 3'd5) match = 1'b1;
      else                   match = (sword[CharCount] == 8'h00);
    end
  end

  always @(posedge clock) begin
    valid_q <= sram_re;
    if (eng_new) ok_q <= 1'b1;
    else if (valid_q) begin
      if (sp || ETX)              ok_q <= 1'b1;
      else if (CharCount < 3'd5)  ok_q <= ok_eff && (rdata == sword[CharCount]);
    end
  end

  always @(posedge clock) if (eng_new) new_pulses <= new_pulses + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_found"}, found, 0);
    check({pfx, "_err"}, err, 0);
    check({pfx, "_eng_new"}, eng_new, 0);
    check({pfx, "_sram_re"}, sram_re, 0);
    check({pfx, "_sram_addr"}, sram_addr, 0);
    check({pfx, "_charcount"}, CharCount, 0);
    check({pfx, "_match_addr"}, match_addr, 0);
    check({pfx, "_word_idx"}, word_idx, 0);
  endtask

  // '#' in the text stands for ETX; the rest of the SRAM is filled with '.'.
  task automatic load_text(input string s);
    for (int i = 0; i < 1024; i++) mem[i] = 8'h2e;
    for (int i = 0; i < s.len(); i++) mem[i] = (s[i] == "#") ? ASCII_ETX : s[i];
  endtask

  task automatic set_word(input string w);
    wl = w.len();
    for (int i = 0; i < 5; i++) sword[i] = (i < wl) ? w[i] : 8'h00;
  endtask

  // Reference search over mem/sword following the sequencer's rules.
  task automatic ref_model(output exp_t e);
    int len, cnt;
    bit ovf, mism;
    logic [7:0] b;
    e = '{found: 1'b0, err: 1'b0, maddr: 10'd0, widx: 10'd0, lat: 0};
    len = 0; cnt = 0; ovf = 0; mism = 0;
    for (int a = 0; a < 1024; a++) begin
      b = mem[a];
      if ((b == ASCII_SP || b == ASCII_ETX) && len != 0 && !ovf && !mism && len == wl) begin
        e.found = 1'b1; e.maddr = a[9:0]; e.widx = cnt[9:0]; e.lat = a + 3;
        return;
      end
      if (b == ASCII_ETX) begin e.lat = a + 3; return; end
      if (a == 1023) begin e.err = 1'b1; e.lat = a + 3; return; end
      if (b == ASCII_SP) begin
        if (len != 0) cnt++;
        len = 0; ovf = 0; mism = 0;
      end else if (len == 5) begin
        ovf = 1;
      end else begin
        if (len >= wl || b != sword[len]) mism = 1;
        len++;
      end
    end
  endtask

  task automatic run_search(input string tag, input bit poke);
    exp_t e, got;
    int edges, pulses0;
    ref_model(e);
    exp_q.push_back(e);
    @(negedge clock);
    pulses0 = new_pulses;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 1;
    check({tag, "_clr_done"}, done, 0);
    check({tag, "_clr_found"}, found, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_eng_new"}, eng_new, 1);
    while (done !== 1'b1 && edges < 3000) begin
      start = poke && (edges == 4);
      @(posedge clock); #1;
      edges++;
    end
    start = 1'b0;
    if (done !== 1'b1) check({tag, "_timeout"}, 1, 0);
    got = exp_q.pop_front();
    check({tag, "_found"}, found, got.found);
    check({tag, "_err"}, err, got.err);
    if (got.found) begin
      check({tag, "_match_addr"}, match_addr, got.maddr);
      check({tag, "_word_idx"}, word_idx, got.widx);
    end
    check({tag, "_latency"}, edges, got.lat);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_sram_re_end"}, sram_re, 0);
    check({tag, "_pulses"}, new_pulses - pulses0, 1);
    $display("search %s: found=%0d err=%0d match_addr=%0d word_idx=%0d cycles=%0d",
             tag, found, err, match_addr, word_idx, edges);
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b0;
    load_text("#");
    set_word("a");
    #3;
    check_zero("rst");
    @(negedge clock);
    reset = 1'b1;

    load_text("cat dog#");        set_word("dog");   run_search("dog", 0);
    load_text("catdog dog#");     set_word("cat");   run_search("ovf_cat", 0);
    load_text("  ab   ab#");      set_word("ab");    run_search("spaces_ab", 0);
    load_text("  ab#");           set_word("");      run_search("empty_word", 0);
    load_text("catdog catdo#");   set_word("catdo"); run_search("five_char", 0);
    load_text("cat dog#");        set_word("dog");   run_search("start_ignored", 1);

    // No terminator anywhere: exhaustion at the last address.
    for (int i = 0; i < 1024; i++) mem[i] = (i % 3 == 2) ? ASCII_SP : ((i % 3 == 0) ? 8'h78 : 8'h79);
    set_word("zz");
    run_search("exhaust", 0);

    // Hit whose terminator is the ETX in the very last address.
    mem[1020] = ASCII_SP; mem[1021] = 8'h61; mem[1022] = 8'h62; mem[1023] = ASCII_ETX;
    set_word("ab");
    run_search("last_addr_hit", 0);

    // Abort mid-scan with reset, then restart cleanly.
    load_text("cat dog#");
    set_word("dog");
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clock);
    reset = 1'b1;
    run_search("after_abort", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/search_sequencer.md
Name: search_sequencer

Overview:
Controller that sequences one text search through the string-match engine. On a host start it pulses the engine's new input and streams text bytes out of the synchronous SRAM from address 0. It drives the engine's CharCount per byte and qualifies the engine's raw match so that empty words and words longer than 5 characters never report a hit. It stops on the first qualified hit, on ETX, or on address exhaustion, and reports the result to the host.

Parameters:
ADDR_W, 10, SRAM address width
MAX_ADDR, 1023, last legal text address; reaching it without a terminator ends the search with err
MAX_WORD, 5, characters per search word (fixed by the engine's 40-bit word)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  host request; sampled in IDLE or DONE only
sram_addr  out  ADDR_W  SRAM read address
sram_re  out  1  SRAM read enable; read data is valid exactly 1 cycle after the address
eng_new  out  1  one-cycle pulse to the engine's new input (loads the search word, clears engine Found/NotFound)
CharCount  out  3  byte position within the current word, to the engine
sp  in  1  engine: current data byte is 0x20
ETX  in  1  engine: current data byte is 0x03
match  in  1  engine: raw combinational match
busy  out  1  search in progress
done  out  1  result valid; held until next start
found  out  1  qualified hit found
err  out  1  MAX_ADDR reached with no ETX and no hit
match_addr  out  ADDR_W  address of the terminator byte of the matching word
word_idx  out  ADDR_W  0-based index of the matching word (non-empty words only)

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; internal len=0, ovf=0.
- States: IDLE, PRIME, SCAN, DONE.
- IDLE/DONE, start=1: next cycle enters PRIME with eng_new=1, sram_addr=0, sram_re=1, CharCount=0. done, found, err, match_addr and word_idx clear, busy=1.
- PRIME (1 cycle): eng_new=0; sram_addr becomes 1; next state SCAN. Start-to-first-valid-byte latency is 2 cycles.
- SCAN: the byte on the engine data bus is mem[sram_addr-1]. sram_addr increments every cycle. CharCount equals len saturated at 5. Priority per cycle:
  1. hit = match & (len!=0) & !ovf. If hit: go to DONE, found=1, match_addr=sram_addr-1, word_idx=current word count.
  2. Else if ETX: go to DONE, found=0.
  3. Else if (sram_addr-1)==MAX_ADDR: go to DONE, err=1.
  4. Else if sp: if len!=0, word count +1. Then len=0 and ovf=0; the next CharCount is 0. Consecutive spaces keep the count unchanged.
  5. Else (text character): if len==MAX_WORD, set ovf=1 and keep len at 5. Otherwise len+1. CharCount 5 makes the engine discard the byte.
- DONE: busy=0, done=1, sram_re=0. Results stay stable until the next start.
- start while busy (PRIME/SCAN) is ignored.
- Reset low mid-search aborts immediately to IDLE with all outputs 0. eng_new is not issued.
- Word counter and address never wrap: the search terminates at MAX_ADDR first.

Decomposition:
- Shared package search_pkg: ASCII_SP=8'h20, ASCII_ETX=8'h03, MAX_WORD=5, CC_W=3, state enum {IDLE,PRIME,SCAN,DONE}.
- One sub-module, word_tracker: holds len, ovf and word count. Inputs are the sp/char events; outputs are CharCount and the hit qualifier.

Test Plan:
- Text "cat dog\x03", search "dog\0\0" -> found=1, word_idx=1, match_addr=7, done asserted 10 cycles after the start cycle.
- Text "catdog dog\x03", search "cat" -> no hit on "catdog" (ovf set, CharCount saturates at 5); found=0, done on ETX at address 10.
- Text "  ab   ab\x03" (leading and repeated spaces), search "ab" -> found=1, word_idx=0, match_addr=4. Empty words are not counted.
- Text with no ETX in a 4-byte SRAM, MAX_ADDR=3 -> done=1, err=1, found=0 after address 3 is consumed.
- Start pulsed during SCAN -> ignored (no eng_new). Reset driven low mid-SCAN -> all outputs 0 at once. A later start gives a correct result with a single eng_new pulse.
- Back-to-back searches: start asserted in DONE -> results clear in the next cycle and eng_new pulses exactly once.
